// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, and a show-ahead FIFO.
// The FIFO count is held explicitly. Overrun and frame errors are sticky until clr_err.
module uart_rx_fifo #(
  parameter int SYS_CLK  = 24000000,
  parameter int BAUDRATE = 115200,
  parameter int FIFO_AW  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               uart_rxd,
  input  logic               rd,
  input  logic               clr_err,
  output logic [7:0]         data,
  output logic               avail,
  output logic [FIFO_AW:0]   count,
  output logic               overrun,
  output logic               frame_err
);

  localparam int DIVISOR = SYS_CLK / BAUDRATE;
  localparam int DEPTH   = 2 ** FIFO_AW;
  localparam int CW      = $clog2(DIVISOR);

  localparam logic [CW-1:0]      FULL_RELOAD = CW'(DIVISOR - 1);
  localparam logic [CW-1:0]      HALF_RELOAD = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0]      SYNC_GUARD  = CW'(2);
  localparam logic [FIFO_AW:0]   FULL_COUNT  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {WAITHI, IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shreg, shreg_next;
  logic          sync1, rx_s;
  logic          push, stop_bad;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= uart_rxd;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= WAITHI;
      cnt     <= SYNC_GUARD;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
    end
  end

  // WAITHI needs the line high for a short run, so the synchronizer's reset ones cannot fake an idle line
  always_comb begin
    state_next   = state;
    cnt_next     = (cnt == '0) ? cnt : cnt - CW'(1);
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    push         = 1'b0;
    stop_bad     = 1'b0;
    case (state)
      WAITHI: begin
        if (!rx_s) begin
          cnt_next = SYNC_GUARD;
        end else if (cnt == '0) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = HALF_RELOAD;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
            cnt_next     = FULL_RELOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shreg_next   = {rx_s, shreg[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          cnt_next     = FULL_RELOAD;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = WAITHI;
            cnt_next   = SYNC_GUARD;
          end
        end
      end
      default: begin
        state_next = WAITHI;
        cnt_next   = SYNC_GUARD;
      end
    endcase
  end

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               pop, full, wr_en, drop;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds
  assign pop   = rd && (count != '0);
  assign full  = (count == FULL_COUNT);
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
      overrun   <= drop     || (overrun   && !clr_err);
      frame_err <= stop_bad || (frame_err && !clr_err);
    end
  end

  assign data  = mem[rd_ptr];
  assign avail = (count != '0);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo. A queue model of received bytes is built from frame start times and the fixed receive latency.
// DUT outputs are compared with the model on every falling edge.
module tb_uart_rx_fifo;

  localparam int SYS_CLK  = 24000000;
  localparam int BAUDRATE = 1500000;
  localparam int FIFO_AW  = 4;
  localparam int DIV      = SYS_CLK / BAUDRATE;
  localparam int DEPTH    = 2 ** FIFO_AW;
  // 2 sync stages + 1 edge leaving IDLE + half a start bit + 8 data bits + half... to the mid-stop sample
  localparam int LAT      = 3 + DIV / 2 + 9 * DIV;

  logic             clk;
  logic             reset_n;
  logic             uart_rxd;
  logic             rd;
  logic             clr_err;
  logic [7:0]       data;
  logic             avail;
  logic [FIFO_AW:0] count;
  logic             overrun;
  logic             frame_err;

  uart_rx_fifo #(.SYS_CLK(SYS_CLK), .BAUDRATE(BAUDRATE), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rxd(uart_rxd), .rd(rd), .clr_err(clr_err),
    .data(data), .avail(avail), .count(count), .overrun(overrun), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [7:0] b;
    bit         ok;
  } ev_t;

  logic [7:0] mq[$];
  ev_t        sched[$];
  ev_t        ev;
  bit         m_ov = 1'b0;
  bit         m_fe = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  // Reference model: the byte queue, the sticky flags, and the frame completions that are scheduled.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset_n) begin
      mq.delete();
      sched.delete();
      m_ov = 1'b0;
      m_fe = 1'b0;
    end else begin
      if (clr_err) begin
        m_ov = 1'b0;
        m_fe = 1'b0;
      end
      if (rd && mq.size() > 0) void'(mq.pop_front());
      while (sched.size() > 0 && sched[0].at == cyc) begin
        ev = sched.pop_front();
        if (!ev.ok) m_fe = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(ev.b);
        else m_ov = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("avail", {31'd0, avail}, {31'd0, mq.size() != 0});
      chk("count", {27'd0, count}, mq.size());
      if (mq.size() > 0) chk("data", {24'd0, data}, {24'd0, mq[0]});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ov});
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // This task must be called #1 after a rising edge. It ends DIV cycles after the stop bit begins.
  task automatic send_frame(input logic [7:0] b, input bit ok);
    ev_t e;
    e.at = cyc + LAT;
    e.b  = b;
    e.ok = ok;
    sched.push_back(e);
    uart_rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(DIV);
    end
    uart_rxd = ok;
    tick(DIV);
  endtask

  task automatic pop_one();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  bit         rand_run;
  logic [7:0] rb;
  bit         rok;

  initial begin
    reset_n  = 1'b0;
    uart_rxd = 1'b1;
    rd       = 1'b0;
    clr_err  = 1'b0;
    tick(3);
    chk("reset_count", {27'd0, count}, 32'd0);
    chk("reset_avail", {31'd0, avail}, 32'd0);
    chk("reset_flags", {30'd0, overrun, frame_err}, 32'd0);
    reset_n = 1'b1;
    tick(8);

    send_frame(8'hA5, 1'b1);
    chk("single_avail", {31'd0, avail}, 32'd1);
    chk("single_count", {27'd0, count}, 32'd1);
    chk("single_data", {24'd0, data}, 32'hA5);
    pop_one();
    chk("single_pop", {27'd0, count}, 32'd0);

    for (int i = 0; i < 16; i++) send_frame(8'(8'h41 + i), 1'b1);
    chk("stream_count", {27'd0, count}, 32'd16);
    chk("stream_ovr", {31'd0, overrun}, 32'd0);
    send_frame(8'h51, 1'b1);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    chk("overrun_count", {27'd0, count}, 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("stream_order", {24'd0, data}, 32'h41 + i);
      pop_one();
    end
    pulse_clr();
    chk("overrun_clr", {31'd0, overrun}, 32'd0);

    send_frame(8'h3C, 1'b0);
    uart_rxd = 1'b0;
    tick(40 * DIV);
    uart_rxd = 1'b1;
    tick(2 * DIV);
    chk("frame_err_set", {31'd0, frame_err}, 32'd1);
    chk("frame_count", {27'd0, count}, 32'd0);
    send_frame(8'h7E, 1'b1);
    chk("after_frame_data", {24'd0, data}, 32'h7E);
    pulse_clr();
    chk("frame_err_clr", {31'd0, frame_err}, 32'd0);
    pop_one();

    uart_rxd = 1'b0;
    tick(DIV / 4);
    uart_rxd = 1'b1;
    tick(3 * DIV);
    chk("glitch_count", {27'd0, count}, 32'd0);
    chk("glitch_flags", {30'd0, overrun, frame_err}, 32'd0);
    send_frame(8'h5A, 1'b1);
    chk("glitch_next", {24'd0, data}, 32'h5A);
    pop_one();

    for (int i = 0; i < 16; i++) send_frame(8'(i * 7 + 3), 1'b1);
    fork
      send_frame(8'h99, 1'b1);
      begin
        tick(LAT - 1);
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
      end
    join
    chk("pushpop_count", {27'd0, count}, 32'd16);
    chk("pushpop_ovr", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("pushpop_last", {24'd0, data}, 32'h99);
      pop_one();
    end

    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    uart_rxd = 1'b0;
    tick(5 * DIV);
    uart_rxd = 1'b1;
    tick(DIV / 2);
    reset_n  = 1'b0;
    uart_rxd = 1'b0;
    tick(3);
    reset_n = 1'b1;
    chk("midreset_count", {27'd0, count}, 32'd0);
    chk("midreset_flags", {30'd0, overrun, frame_err}, 32'd0);
    tick(20 * DIV);
    chk("lowline_count", {27'd0, count}, 32'd0);
    chk("lowline_ferr", {31'd0, frame_err}, 32'd0);
    uart_rxd = 1'b1;
    tick(2 * DIV);
    send_frame(8'h12, 1'b1);
    chk("midreset_next", {24'd0, data}, 32'h12);
    pop_one();

    rand_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          rb  = 8'($urandom);
          rok = ($urandom_range(0, 9) != 0);
          send_frame(rb, rok);
          if (!rok) begin
            uart_rxd = 1'b1;
            tick(DIV);
          end else begin
            tick($urandom_range(1, 20));
          end
        end
        rand_run = 1'b0;
      end
      begin
        while (rand_run) begin
          rd      = ($urandom_range(0, 199) == 0);
          clr_err = ($urandom_range(0, 299) == 0);
          tick(1);
        end
        rd      = 1'b0;
        clr_err = 1'b0;
      end
    join
    for (int i = 0; i < 20; i++) pop_one();
    chk("drain_count", {27'd0, count}, 32'd0);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
